pi1_wsmem: RTL and testbench
============================

Name: pi1_wsmem

Overview:
- Parametrised successor to the simulation scratch memory slave on the pi1r interconnect.
- Adds programmable wait states, an atomic read-write (swap) operation, a write-protected low region with a dropped-write counter, and power-of-two address wrap.
- Sits as a PerInt slave next to the UART and invalid-device slaves in simulation and small FPGA tops.
- The memory array is preloaded at elaboration from SRCFILE.

Parameters:
- ARCHBITSZ, 32: data width in bits; 16, 32 or 64.
- SIZE, 1024: memory depth in words; power of two, at least 2.
- DELAY, 0: wait cycles per operation; 0..255.
- ROSZ, 0: number of words, starting at index 0, that are write-protected; 0..SIZE.
- SRCFILE, "": hex preload file for $readmemh; no preload when empty.
- ADDRBITSZ, ARCHBITSZ-clog2(ARCHBITSZ/8): word address width; derived.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- pi1_op_i  in  2  operation: 0 NOOP, 1 WROP, 2 RDOP, 3 RWOP.
- pi1_addr_i  in  ADDRBITSZ  word offset within this slave's window.
- pi1_data_i  in  ARCHBITSZ  write data.
- pi1_data_o  out  ARCHBITSZ  read data.
- pi1_sel_i  in  ARCHBITSZ/8  byte enables.
- pi1_rdy_o  out  1  slave ready.
- pi1_mapsz_o  out  ADDRBITSZ  window size in words; constant SIZE.
- wrprot_cnt_o  out  16  saturating count of writes dropped due to write protection.

Behaviour:
- Reset (rst_i low, async): pi1_rdy_o=1, pi1_data_o=0, wrprot_cnt_o=0, FSM=IDLE, wait counter=0.
  - Memory array is not reset.
  - Any in-flight operation is cancelled: no array write occurs and pi1_data_o is not updated.
- Indexing: idx = pi1_addr_i[clog2(SIZE)-1:0]. Upper address bits are ignored, so addresses wrap modulo SIZE.
- Acceptance: an op is accepted on a rising edge where pi1_rdy_o=1 and pi1_op_i!=0. On acceptance, op, idx, data and sel are latched.
- DELAY=0:
  - The op completes on the accepting edge.
  - pi1_rdy_o stays 1 and back-to-back ops are accepted every cycle.
- DELAY=N>0:
  - FSM goes IDLE->WAIT on acceptance; pi1_rdy_o=0 for exactly N cycles.
  - The op completes on the Nth edge after acceptance; FSM returns to IDLE and pi1_rdy_o=1.
  - Inputs during WAIT are ignored.
- Completion semantics (applied to the latched values):
  - RDOP: pi1_data_o <= mem[idx].
  - WROP: mem[idx] byte b <= data byte b for each sel[b]=1. pi1_data_o is unchanged.
  - RWOP: pi1_data_o <= old mem[idx], and the write applies under sel. This is atomic, with no window between the read and the write.
  - sel=0 on WROP/RWOP performs no byte writes. This does not count as a protection event.
- pi1_data_o holds its value until the next RDOP/RWOP completion. The master samples it in the first cycle pi1_rdy_o=1 after acceptance.
- Write protection: for idx<ROSZ, WROP/RWOP perform no byte writes.
  - RWOP still returns the old data.
  - wrprot_cnt_o increments by 1 at completion and saturates at 16'hFFFF.
  - ROSZ=0 disables protection.
- The NOOP level never changes state.
- pi1_mapsz_o = SIZE, constant, including during reset.

Test Plan:
- Reset/defaults: DELAY=2, hold rst_i=0 for 3 cycles, then release -> pi1_rdy_o=1, pi1_data_o=0, wrprot_cnt_o=0, pi1_mapsz_o=1024.
- Byte-lane write/read: DELAY=0, WROP addr 5 data 32'hAABBCCDD sel 4'b1111, then WROP addr 5 data 32'h11223344 sel 4'b0101, then RDOP addr 5 -> next cycle pi1_data_o=32'hAA22CC44. Ops are back-to-back with rdy never low.
- Wait states and wrap: DELAY=3, SIZE=1024, WROP addr 1024+7 data 32'h0000BEEF sel 4'hF -> rdy low exactly 3 cycles. Then RDOP addr 7 -> rdy low 3 cycles, then pi1_data_o=32'h0000BEEF. Inputs toggled during WAIT have no effect.
- Atomic swap: mem[9]=32'h12345678, RWOP addr 9 data 32'hCAFEF00D sel 4'hF -> pi1_data_o=32'h12345678. A following RDOP 9 returns 32'hCAFEF00D.
- Write protection: ROSZ=16, mem[3]=32'h5A5A5A5A.
  - WROP addr 3 -> no change, wrprot_cnt_o=1.
  - RWOP addr 3 -> returns 32'h5A5A5A5A, memory unchanged, count=2.
  - WROP addr 16 -> written, count stays 2.
  - Preload count to 16'hFFFF via forced writes -> stays 16'hFFFF.
- Reset mid-operation: DELAY=4, WROP addr 2 data 32'hDEADBEEF, assert rst_i=0 two cycles after acceptance -> pi1_rdy_o=1 immediately (async). A following RDOP 2 returns the pre-op value, not 32'hDEADBEEF.

Source files
------------

// File: rtl/pi1_wsmem_if.sv
// PerInt (pi1r) slave bus bundle for the wait-state scratch memory.
// The master drives op/addr/data/sel; the slave returns data, ready and its window size.
interface pi1_wsmem_if #(
  parameter int ARCHBITSZ = 32,
  parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
);
  logic [1:0]             pi1_op_i;
  logic [ADDRBITSZ-1:0]   pi1_addr_i;
  logic [ARCHBITSZ-1:0]   pi1_data_i;
  logic [ARCHBITSZ-1:0]   pi1_data_o;
  logic [ARCHBITSZ/8-1:0] pi1_sel_i;
  logic                   pi1_rdy_o;
  logic [ADDRBITSZ-1:0]   pi1_mapsz_o;

  modport master (
    output pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
    input  pi1_data_o, pi1_rdy_o, pi1_mapsz_o
  );

  modport slave (
    input  pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
    output pi1_data_o, pi1_rdy_o, pi1_mapsz_o
  );
endinterface

// File: rtl/pi1_wsmem.sv
// Scratch memory slave with programmable wait states, atomic swap,
// a write-protected low region with a dropped-write counter, and address wrap.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready; a non-NOOP op is accepted (and completed if DELAY=0)
// ST_WAIT | op latched; counting down wait cycles, completes at count 0
module pi1_wsmem #(
  parameter int    ARCHBITSZ = 32,
  parameter int    SIZE      = 1024,
  parameter int    DELAY     = 0,
  parameter int    ROSZ      = 0,
  parameter string SRCFILE   = "",
  parameter int    ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  pi1_wsmem_if.slave  pi1,
  output logic [15:0] wrprot_cnt_o
);

  localparam int IDXW = $clog2(SIZE);
  localparam int SELW = ARCHBITSZ / 8;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  logic [ARCHBITSZ-1:0] mem [SIZE];

  state_t               state, state_nxt;
  logic [7:0]           wait_cnt, wait_cnt_nxt;
  logic                 accept, done, do_op;
  logic [1:0]           op_q;
  logic [IDXW-1:0]      idx_q;
  logic [ARCHBITSZ-1:0] data_q;
  logic [SELW-1:0]      sel_q;
  logic [ARCHBITSZ-1:0] rdata_q;

  logic [1:0]           c_op;
  logic [IDXW-1:0]      c_idx;
  logic [ARCHBITSZ-1:0] c_data;
  logic [SELW-1:0]      c_sel;
  logic                 prot, wr_en;
  logic                 unused_addr;

  assign unused_addr = ^pi1.pi1_addr_i[ADDRBITSZ-1:IDXW];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    accept       = 1'b0;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pi1.pi1_op_i != 2'd0) begin
          accept = 1'b1;
          if (DELAY == 0) begin
            done = 1'b1;
          end else begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = 8'(DELAY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 8'd0) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q   <= 2'd0;
      idx_q  <= '0;
      data_q <= '0;
      sel_q  <= '0;
    end else if (accept) begin
      op_q   <= pi1.pi1_op_i;
      idx_q  <= pi1.pi1_addr_i[IDXW-1:0];
      data_q <= pi1.pi1_data_i;
      sel_q  <= pi1.pi1_sel_i;
    end
  end

  // With no wait states the op completes on the accepting edge, straight from the bus.
  assign c_op   = (DELAY == 0) ? pi1.pi1_op_i             : op_q;
  assign c_idx  = (DELAY == 0) ? pi1.pi1_addr_i[IDXW-1:0] : idx_q;
  assign c_data = (DELAY == 0) ? pi1.pi1_data_i           : data_q;
  assign c_sel  = (DELAY == 0) ? pi1.pi1_sel_i            : sel_q;

  // The array has no reset, so completion is gated while reset is held.
  assign do_op = done && rst_i;
  assign prot  = (ROSZ > 0) && (int'(c_idx) < ROSZ);
  assign wr_en = do_op && c_op[0] && !prot;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < SELW; b++) begin
        if (c_sel[b]) mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q      <= '0;
      wrprot_cnt_o <= 16'd0;
    end else begin
      if (do_op && c_op[1]) rdata_q <= mem[c_idx];
      if (do_op && c_op[0] && prot && (c_sel != '0) && (wrprot_cnt_o != 16'hFFFF))
        wrprot_cnt_o <= wrprot_cnt_o + 16'd1;
    end
  end

  assign pi1.pi1_data_o  = rdata_q;
  assign pi1.pi1_rdy_o   = (state == ST_IDLE);
  assign pi1.pi1_mapsz_o = ADDRBITSZ'(SIZE);

endmodule

// File: tb/tb_pi1_wsmem.sv
// Directed bench for pi1_wsmem: a zero-wait protected instance and a three-wait instance,
// with read results queued at issue time and compared when the slave delivers them.
module tb_pi1_wsmem;

  localparam logic [1:0] NOOP = 2'd0, WROP = 2'd1, RDOP = 2'd2, RWOP = 2'd3;
  localparam int DELAY_S = 3;
  localparam int ROSZ_F  = 16;

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_f, rst_s;
  logic [15:0] cnt_f, cnt_s;
  int          n_chk = 0;
  int          n_err = 0;
  int          mcnt_f = 0;
  logic [31:0] mdl_f [1024];
  logic [31:0] mdl_s [1024];
  exp_t        sb_f [$];
  exp_t        sb_s [$];

  always #5 clk = ~clk;

  pi1_wsmem_if #(.ARCHBITSZ(32), .ADDRBITSZ(30)) bus_f ();
  pi1_wsmem_if #(.ARCHBITSZ(32), .ADDRBITSZ(30)) bus_s ();

  pi1_wsmem #(.ARCHBITSZ(32), .SIZE(1024), .DELAY(0), .ROSZ(ROSZ_F)) u_fast (
    .clk_i(clk), .rst_i(rst_f), .pi1(bus_f), .wrprot_cnt_o(cnt_f));

  pi1_wsmem #(.ARCHBITSZ(32), .SIZE(1024), .DELAY(DELAY_S), .ROSZ(0)) u_slow (
    .clk_i(clk), .rst_i(rst_s), .pi1(bus_s), .wrprot_cnt_o(cnt_s));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic pop_f();
    exp_t e;
    if (sb_f.size() != 0) begin
      e = sb_f.pop_front();
      chk(e.tag, bus_f.pi1_data_o, e.data);
    end
  endtask

  // Zero-wait op: drive on the falling edge, the next rising edge completes it.
  task automatic op_f(input logic [1:0] op, input logic [29:0] addr, input logic [31:0] d,
                      input logic [3:0] sel, input string tag);
    int idx;
    @(negedge clk);
    pop_f();
    chk({tag, "_rdy"}, bus_f.pi1_rdy_o, 1);
    bus_f.pi1_op_i   = op;
    bus_f.pi1_addr_i = addr;
    bus_f.pi1_data_i = d;
    bus_f.pi1_sel_i  = sel;
    idx = int'(addr[9:0]);
    if (op[1]) sb_f.push_back('{tag, mdl_f[idx]});
    if (op[0] && sel != 4'd0) begin
      if (idx < ROSZ_F) mcnt_f = (mcnt_f == 65535) ? 65535 : mcnt_f + 1;
      else mdl_f[idx] = merge(mdl_f[idx], d, sel);
    end
  endtask

  task automatic idle_f();
    @(negedge clk);
    pop_f();
    bus_f.pi1_op_i = NOOP;
  endtask

  // Waited op: counts ready-low cycles while scribbling on the bus, then checks read data.
  task automatic op_s(input logic [1:0] op, input logic [29:0] addr, input logic [31:0] d,
                      input logic [3:0] sel, input string tag);
    int   idx;
    int   low;
    exp_t e;
    @(negedge clk);
    bus_s.pi1_op_i   = op;
    bus_s.pi1_addr_i = addr;
    bus_s.pi1_data_i = d;
    bus_s.pi1_sel_i  = sel;
    idx = int'(addr[9:0]);
    if (op[1]) sb_s.push_back('{tag, mdl_s[idx]});
    if (op[0]) mdl_s[idx] = merge(mdl_s[idx], d, sel);
    @(posedge clk);
    @(negedge clk);
    bus_s.pi1_op_i   = RWOP;
    bus_s.pi1_addr_i = addr ^ 30'h1;
    bus_s.pi1_data_i = ~d;
    bus_s.pi1_sel_i  = 4'hF;
    low = 0;
    while (bus_s.pi1_rdy_o !== 1'b1 && low < 20) begin
      low++;
      @(negedge clk);
    end
    bus_s.pi1_op_i = NOOP;
    chk({tag, "_wait"}, low, DELAY_S);
    if (sb_s.size() != 0) begin
      e = sb_s.pop_front();
      chk(e.tag, bus_s.pi1_data_o, e.data);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_f = 1'b0;
    rst_s = 1'b0;
    bus_f.pi1_op_i = NOOP; bus_f.pi1_addr_i = '0; bus_f.pi1_data_i = '0; bus_f.pi1_sel_i = '0;
    bus_s.pi1_op_i = NOOP; bus_s.pi1_addr_i = '0; bus_s.pi1_data_i = '0; bus_s.pi1_sel_i = '0;
    u_fast.mem[3] = 32'h5A5A5A5A;
    mdl_f[3]      = 32'h5A5A5A5A;

    repeat (3) @(negedge clk);
    chk("mapsz_in_reset", bus_s.pi1_mapsz_o, 1024);
    rst_f = 1'b1;
    rst_s = 1'b1;
    #1;
    chk("rst_rdy_s", bus_s.pi1_rdy_o, 1);
    chk("rst_data_s", bus_s.pi1_data_o, 0);
    chk("rst_cnt_s", cnt_s, 0);
    chk("rst_mapsz_s", bus_s.pi1_mapsz_o, 1024);
    chk("rst_data_f", bus_f.pi1_data_o, 0);
    chk("rst_cnt_f", cnt_f, 0);

    // Zero-wait instance: byte lanes, wrap, swap, all back-to-back.
    op_f(WROP, 30'd21, 32'hAABBCCDD, 4'b1111, "bl_wr0");
    op_f(WROP, 30'd21, 32'h11223344, 4'b0101, "bl_wr1");
    op_f(RDOP, 30'd21, 32'h0,        4'b0000, "bl_rd");
    op_f(WROP, 30'd1024 + 30'd30, 32'h0BADCAFE, 4'hF, "wrap_wr");
    op_f(RDOP, 30'd30, 32'h0, 4'h0, "wrap_rd");
    op_f(WROP, 30'd25, 32'h12345678, 4'hF, "swap_init");
    op_f(RWOP, 30'd25, 32'hCAFEF00D, 4'hF, "swap_old");
    op_f(RDOP, 30'd25, 32'h0, 4'h0, "swap_new");
    idle_f();

    // Write protection on the low 16 words.
    op_f(WROP, 30'd3, 32'hFFFFFFFF, 4'hF, "prot_wr");
    idle_f();
    chk("prot_cnt1", cnt_f, mcnt_f);
    op_f(RWOP, 30'd3, 32'h00000000, 4'hF, "prot_rw");
    op_f(RDOP, 30'd3, 32'h0, 4'h0, "prot_rd");
    op_f(WROP, 30'd16, 32'h600DF00D, 4'hF, "unprot_wr");
    op_f(WROP, 30'd15, 32'h77777777, 4'h0, "prot_sel0");
    op_f(WROP, 30'd15, 32'h77777777, 4'hF, "prot_edge");
    op_f(RDOP, 30'd16, 32'h0, 4'h0, "unprot_rd");
    idle_f();
    chk("prot_cnt3", cnt_f, mcnt_f);

    // Drive protected writes continuously to reach the saturation point.
    @(negedge clk);
    bus_f.pi1_op_i = WROP; bus_f.pi1_addr_i = 30'd0; bus_f.pi1_sel_i = 4'hF;
    repeat (65531) @(posedge clk);
    mcnt_f = mcnt_f + 65531;
    idle_f();
    chk("cnt_fffe", cnt_f, mcnt_f);
    op_f(WROP, 30'd0, 32'h1, 4'h1, "sat_wr1");
    idle_f();
    chk("cnt_ffff", cnt_f, 16'hFFFF);
    op_f(WROP, 30'd1, 32'h1, 4'h1, "sat_wr2");
    op_f(RWOP, 30'd2, 32'h1, 4'h1, "sat_wr3");
    idle_f();
    chk("cnt_hold", cnt_f, 16'hFFFF);

    // Three-wait instance: wrap, swap, ignored inputs during wait.
    op_s(WROP, 30'd1024 + 30'd7, 32'h0000BEEF, 4'hF, "ws_wr");
    op_s(RDOP, 30'd7, 32'h0, 4'h0, "ws_rd");
    op_s(WROP, 30'd9, 32'h12345678, 4'hF, "ws_swap_init");
    op_s(RWOP, 30'd9, 32'hCAFEF00D, 4'hF, "ws_swap_old");
    op_s(RDOP, 30'd9, 32'h0, 4'h0, "ws_swap_new");
    op_s(WROP, 30'd2, 32'h01020304, 4'hF, "ws_pre_wr");
    op_s(RDOP, 30'd2, 32'h0, 4'h0, "ws_pre_rd");

    // Reset in the middle of a waited write cancels it.
    @(negedge clk);
    bus_s.pi1_op_i = WROP; bus_s.pi1_addr_i = 30'd2;
    bus_s.pi1_data_i = 32'hDEADBEEF; bus_s.pi1_sel_i = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_s = 1'b0;
    #1;
    chk("midrst_rdy", bus_s.pi1_rdy_o, 1);
    chk("midrst_data", bus_s.pi1_data_o, 0);
    @(negedge clk);
    bus_s.pi1_op_i = NOOP;
    @(negedge clk);
    rst_s = 1'b1;
    op_s(RDOP, 30'd2, 32'h0, 4'h0, "midrst_rd");
    chk("ws_cnt_zero", cnt_s, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
